rf_bank_read_server: RTL and testbench



---
 rtl/rf_bank_read_server.sv | 174 +++++++++++++++++
 tb/tb_rf_bank_read_server.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_bank_read_server.sv
// Four single-ported register-file banks with per-bank read request queues.
// Optional: RF_WB_BYPASS_EN forwards a writeback to a same-row queued read.
module rf_bank_read_server #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 3,
  parameter int QD     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_en,
  output logic              req_rdy,
  input  logic [ROW_W-1:0]  rowid_a,
  input  logic [1:0]        bankid_a,
  input  logic [ROW_W-1:0]  rowid_b,
  input  logic [1:0]        bankid_b,
  input  logic [1:0]        req_ocid,
  input  logic              wb_en,
  input  logic [1:0]        wb_bank,
  input  logic [ROW_W-1:0]  wb_row,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] bk_0_data,
  output logic              bk_0_vld,
  output logic [1:0]        bk_0_ocid,
  output logic              bk_0_opsel,
  output logic              bk_0_bz,
  output logic [DATA_W-1:0] bk_1_data,
  output logic              bk_1_vld,
  output logic [1:0]        bk_1_ocid,
  output logic              bk_1_opsel,
  output logic              bk_1_bz,
  output logic [DATA_W-1:0] bk_2_data,
  output logic              bk_2_vld,
  output logic [1:0]        bk_2_ocid,
  output logic              bk_2_opsel,
  output logic              bk_2_bz,
  output logic [DATA_W-1:0] bk_3_data,
  output logic              bk_3_vld,
  output logic [1:0]        bk_3_ocid,
  output logic              bk_3_opsel,
  output logic              bk_3_bz
);

  localparam int PW = (QD > 1) ? $clog2(QD) : 1;
  localparam int CW = $clog2(QD + 1);

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(QD - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [3:0]        w_ok;
  logic [3:0]        w_vld;
  logic [3:0]        w_sel;
  logic [3:0]        w_bz;
  logic [1:0]        w_oc   [4];
  logic [DATA_W-1:0] w_data [4];
  logic              w_acc;

  // A pair is admitted only if every bank has room for its share
  assign req_rdy = &w_ok;
  assign w_acc   = req_en & req_rdy;

  for (genvar k = 0; k < 4; k++) begin : g_bank
    localparam logic [1:0] K = 2'(k);

    logic [ROW_W-1:0]  r_row [QD];
    logic [1:0]        r_oc  [QD];
    logic [QD-1:0]     r_sel;
    logic [DATA_W-1:0] r_mem [2**ROW_W];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [PW-1:0]     w_wp1;
    logic [PW-1:0]     w_bpos;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_free;
    logic [1:0]        w_need;
    logic              w_hit_a;
    logic              w_hit_b;
    logic              w_enq_a;
    logic              w_enq_b;
    logic              w_wb;
    logic              w_fwd;
    logic              w_pop;
    logic              r_vld;
    logic              r_sel_o;
    logic [1:0]        r_oc_o;
    logic [DATA_W-1:0] r_data;

    assign w_hit_a = (bankid_a == K);
    assign w_hit_b = (bankid_b == K);
    assign w_need  = {1'b0, w_hit_a} + {1'b0, w_hit_b};
    assign w_free  = CW'(QD) - r_cnt;
    assign w_ok[k] = (w_free >= CW'(w_need));
    assign w_bz[k] = (w_free < CW'(2));
    assign w_enq_a = w_acc & w_hit_a;
    assign w_enq_b = w_acc & w_hit_b;
    assign w_wp1   = f_inc(r_wp);
    assign w_bpos  = w_enq_a ? w_wp1 : r_wp;
    assign w_wb    = wb_en & (wb_bank == K);
`ifdef RF_WB_BYPASS_EN
    assign w_fwd   = w_wb & (r_row[r_rp] == wb_row);
`else
    assign w_fwd   = 1'b0;
`endif
    // Writeback owns the port; a read only proceeds when forwarded
    assign w_pop   = (r_cnt != '0) & (~w_wb | w_fwd);

    always_ff @(posedge clk) begin
      if (w_enq_a) begin
        r_row[r_wp] <= rowid_a;
        r_oc[r_wp]  <= req_ocid;
        r_sel[r_wp] <= 1'b0;
      end
      if (w_enq_b) begin
        r_row[w_bpos] <= rowid_b;
        r_oc[w_bpos]  <= req_ocid;
        r_sel[w_bpos] <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (w_wb) r_mem[wb_row] <= wb_data;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt   <= '0;
        r_wp    <= '0;
        r_rp    <= '0;
        r_vld   <= 1'b0;
        r_sel_o <= 1'b0;
        r_oc_o  <= '0;
        r_data  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(w_enq_a) + CW'(w_enq_b) - CW'(w_pop);
        if (w_enq_a && w_enq_b) r_wp <= f_inc(w_wp1);
        else if (w_enq_a || w_enq_b) r_wp <= w_wp1;
        if (w_pop) r_rp <= f_inc(r_rp);
        r_vld <= w_pop;
        if (w_pop) begin
          r_data  <= w_fwd ? wb_data : r_mem[r_row[r_rp]];
          r_oc_o  <= r_oc[r_rp];
          r_sel_o <= r_sel[r_rp];
        end
      end
    end

    assign w_vld[k]  = r_vld;
    assign w_sel[k]  = r_sel_o;
    assign w_oc[k]   = r_oc_o;
    assign w_data[k] = r_data;
  end

  assign bk_0_data  = w_data[0];
  assign bk_0_vld   = w_vld[0];
  assign bk_0_ocid  = w_oc[0];
  assign bk_0_opsel = w_sel[0];
  assign bk_0_bz    = w_bz[0];
  assign bk_1_data  = w_data[1];
  assign bk_1_vld   = w_vld[1];
  assign bk_1_ocid  = w_oc[1];
  assign bk_1_opsel = w_sel[1];
  assign bk_1_bz    = w_bz[1];
  assign bk_2_data  = w_data[2];
  assign bk_2_vld   = w_vld[2];
  assign bk_2_ocid  = w_oc[2];
  assign bk_2_opsel = w_sel[2];
  assign bk_2_bz    = w_bz[2];
  assign bk_3_data  = w_data[3];
  assign bk_3_vld   = w_vld[3];
  assign bk_3_ocid  = w_oc[3];
  assign bk_3_opsel = w_sel[3];
  assign bk_3_bz    = w_bz[3];

endmodule

// File: tb/tb_rf_bank_read_server.sv
// Directed bench for rf_bank_read_server.
// Build with +define+RF_WB_BYPASS_EN to cover the forwarding variant.
module tb_rf_bank_read_server;
  localparam int DATA_W = 32;
  localparam int ROW_W  = 3;

  logic clk = 1'b0;
  logic rst;
  logic req_en, req_rdy;
  logic [ROW_W-1:0] rowid_a, rowid_b, wb_row;
  logic [1:0] bankid_a, bankid_b, req_ocid, wb_bank;
  logic wb_en;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] bk_0_data, bk_1_data, bk_2_data, bk_3_data;
  logic bk_0_vld, bk_1_vld, bk_2_vld, bk_3_vld;
  logic [1:0] bk_0_ocid, bk_1_ocid, bk_2_ocid, bk_3_ocid;
  logic bk_0_opsel, bk_1_opsel, bk_2_opsel, bk_3_opsel;
  logic bk_0_bz, bk_1_bz, bk_2_bz, bk_3_bz;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_bank_read_server #(.DATA_W(DATA_W), .ROW_W(ROW_W), .QD(4)) dut (
    .clk(clk), .rst(rst),
    .req_en(req_en), .req_rdy(req_rdy),
    .rowid_a(rowid_a), .bankid_a(bankid_a),
    .rowid_b(rowid_b), .bankid_b(bankid_b),
    .req_ocid(req_ocid),
    .wb_en(wb_en), .wb_bank(wb_bank), .wb_row(wb_row), .wb_data(wb_data),
    .bk_0_data(bk_0_data), .bk_0_vld(bk_0_vld), .bk_0_ocid(bk_0_ocid),
    .bk_0_opsel(bk_0_opsel), .bk_0_bz(bk_0_bz),
    .bk_1_data(bk_1_data), .bk_1_vld(bk_1_vld), .bk_1_ocid(bk_1_ocid),
    .bk_1_opsel(bk_1_opsel), .bk_1_bz(bk_1_bz),
    .bk_2_data(bk_2_data), .bk_2_vld(bk_2_vld), .bk_2_ocid(bk_2_ocid),
    .bk_2_opsel(bk_2_opsel), .bk_2_bz(bk_2_bz),
    .bk_3_data(bk_3_data), .bk_3_vld(bk_3_vld), .bk_3_ocid(bk_3_ocid),
    .bk_3_opsel(bk_3_opsel), .bk_3_bz(bk_3_bz)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [1:0] b, input logic [ROW_W-1:0] r,
                          input logic [DATA_W-1:0] d);
    wb_en = 1'b1; wb_bank = b; wb_row = r; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic req(input logic [ROW_W-1:0] ra, input logic [1:0] ba,
                     input logic [ROW_W-1:0] rb, input logic [1:0] bb,
                     input logic [1:0] oc);
    req_en = 1'b1; rowid_a = ra; bankid_a = ba;
    rowid_b = rb; bankid_b = bb; req_ocid = oc;
  endtask

  function automatic logic [DATA_W-1:0] m1(input int r);
    return (r == 5) ? 32'hB5 : 32'(32'h100 + r);
  endfunction

  logic [3:0] all_vld, all_bz;
  assign all_vld = {bk_3_vld, bk_2_vld, bk_1_vld, bk_0_vld};
  assign all_bz  = {bk_3_bz, bk_2_bz, bk_1_bz, bk_0_bz};

  logic [63:0] exp_q[$];

  initial begin
    int sent, got, cyc;
    logic [63:0] e;
    rst = 1'b0; req_en = 1'b0; wb_en = 1'b0;
    rowid_a = '0; rowid_b = '0; bankid_a = '0; bankid_b = '0;
    req_ocid = '0; wb_bank = '0; wb_row = '0; wb_data = '0;
    #2;
    check("rst_vld", 64'(all_vld), 64'h0);
    check("rst_bz", 64'(all_bz), 64'h0);
    check("rst_rdy", 64'(req_rdy), 64'h1);
    check("rst_data", 64'(bk_0_data), 64'h0);
    #10 rst = 1'b1;
    tick();

    wb_write(2'd0, 3'd2, 32'hA2);
    for (int r = 0; r < 8; r++) wb_write(2'd1, 3'(r), m1(r));
    wb_write(2'd2, 3'd1, 32'h21);
    wb_write(2'd2, 3'd4, 32'h24);
    wb_write(2'd3, 3'd6, 32'h36);

    // Dual-bank pair: latency 2
    req(3'd2, 2'd0, 3'd5, 2'd1, 2'd3);
    tick(); req_en = 1'b0;
    check("t1_c1_vld0", 64'(bk_0_vld), 64'h0);
    tick();
    check("t1_b0", 64'({bk_0_vld, bk_0_ocid, bk_0_opsel, bk_0_data}),
          {31'h0, 1'b1, 2'd3, 1'b0, 32'hA2});
    check("t1_b1", 64'({bk_1_vld, bk_1_ocid, bk_1_opsel, bk_1_data}),
          {31'h0, 1'b1, 2'd3, 1'b1, 32'hB5});
    tick();
    check("t1_one_shot", 64'({bk_0_vld, bk_1_vld}), 64'h0);

    // Same-bank pair: A then B
    req(3'd1, 2'd2, 3'd4, 2'd2, 2'd1);
    tick(); req_en = 1'b0;
    tick();
    check("t2_a", 64'({bk_2_vld, bk_2_ocid, bk_2_opsel, bk_2_data}),
          {31'h0, 1'b1, 2'd1, 1'b0, 32'h21});
    tick();
    check("t2_b", 64'({bk_2_vld, bk_2_ocid, bk_2_opsel, bk_2_data}),
          {31'h0, 1'b1, 2'd1, 1'b1, 32'h24});
    tick();
    check("t2_idle", 64'(bk_2_vld), 64'h0);

    // Writeback starves bank 0, queue fills
    wb_en = 1'b1; wb_bank = 2'd0; wb_row = 3'd7; wb_data = 32'h70;
    req(3'd2, 2'd0, 3'd7, 2'd0, 2'd0);
    #1 check("t3_rdy1", 64'(req_rdy), 64'h1);
    tick();
    check("t3_bz_half", 64'(bk_0_bz), 64'h0);
    req(3'd7, 2'd0, 3'd2, 2'd0, 2'd1);
    tick();
    check("t3_bz_full", 64'(bk_0_bz), 64'h1);
    check("t3_vld_a", 64'(bk_0_vld), 64'h0);
    req(3'd3, 2'd0, 3'd3, 2'd0, 2'd2);
    #1 check("t3_rdy0", 64'(req_rdy), 64'h0);
    tick(); req_en = 1'b0;
    check("t3_vld_b", 64'(bk_0_vld), 64'h0);
    check("t3_bz_hold", 64'(bk_0_bz), 64'h1);
    tick();
    check("t3_vld_c", 64'(bk_0_vld), 64'h0);
    wb_en = 1'b0;
    tick();
    check("t3_d0", 64'({bk_0_vld, bk_0_ocid, bk_0_opsel, bk_0_data}),
          {31'h0, 1'b1, 2'd0, 1'b0, 32'hA2});
    tick();
    check("t3_d1", 64'({bk_0_vld, bk_0_ocid, bk_0_opsel, bk_0_data}),
          {31'h0, 1'b1, 2'd0, 1'b1, 32'h70});
    tick();
    check("t3_d2", 64'({bk_0_vld, bk_0_ocid, bk_0_opsel, bk_0_data}),
          {31'h0, 1'b1, 2'd1, 1'b0, 32'h70});
    tick();
    check("t3_d3", 64'({bk_0_vld, bk_0_ocid, bk_0_opsel, bk_0_data}),
          {31'h0, 1'b1, 2'd1, 1'b1, 32'hA2});
    tick();
    check("t3_drained", 64'({bk_0_vld, bk_0_bz}), 64'h0);

    // Writeback to the queued row in C+1
    req(3'd6, 2'd3, 3'd1, 2'd2, 2'd2);
    tick(); req_en = 1'b0;
    wb_en = 1'b1; wb_bank = 2'd3; wb_row = 3'd6; wb_data = 32'h77;
    tick(); wb_en = 1'b0;
`ifdef RF_WB_BYPASS_EN
    check("t4_c2", 64'({bk_3_vld, bk_3_data}), {31'h0, 1'b1, 32'h77});
    tick();
    check("t4_c3", 64'(bk_3_vld), 64'h0);
`else
    check("t4_c2", 64'(bk_3_vld), 64'h0);
    tick();
    check("t4_c3", 64'({bk_3_vld, bk_3_data}), {31'h0, 1'b1, 32'h77});
`endif
    tick();

    // Ten back-to-back pairs to bank 1
    sent = 0; got = 0; cyc = 0;
    while ((sent < 10 || got < 20) && cyc < 300) begin
      if (bk_1_vld) begin
        if (exp_q.size() == 0) check("wrap_extra", 64'h1, 64'h0);
        else begin
          e = exp_q.pop_front();
          check("wrap_out", 64'({bk_1_ocid, bk_1_opsel, bk_1_data}), e);
          got++;
        end
      end
      if (sent < 10) begin
        req(3'(sent % 8), 2'd1, 3'((sent + 3) % 8), 2'd1, 2'(sent % 4));
        #1;
        if (req_rdy) begin
          exp_q.push_back(64'({2'(sent % 4), 1'b0, m1(sent % 8)}));
          exp_q.push_back(64'({2'(sent % 4), 1'b1, m1((sent + 3) % 8)}));
          sent++;
        end
      end else req_en = 1'b0;
      tick();
      cyc++;
    end
    req_en = 1'b0;
    check("wrap_count", 64'(got), 64'd20);
    tick();
    check("wrap_idle", 64'(bk_1_vld), 64'h0);

    // Async reset with entries queued
    wb_en = 1'b1; wb_bank = 2'd2; wb_row = 3'd0; wb_data = 32'h20;
    req(3'd1, 2'd2, 3'd4, 2'd2, 2'd0);
    tick();
    req(3'd1, 2'd2, 3'd2, 2'd0, 2'd1);
    tick(); req_en = 1'b0;
    tick();
    check("t6_pre_vld0", 64'(bk_0_vld), 64'h1);
    check("t6_pre_bz2", 64'(bk_2_bz), 64'h1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_vld", 64'(all_vld), 64'h0);
    check("t6_rst_bz", 64'(all_bz), 64'h0);
    wb_en = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_no_stale", 64'(all_vld), 64'h0);
    end
    check("t6_rdy", 64'(req_rdy), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
